// File: rtl/bomb_pkg.sv
// Shared types, constants and the blast-area test for the bomb/stun datapath.
// Coordinates are compared as plain unsigned integers, so nothing wraps at the grid edge.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    EXPLODE  = 2'd2,
    COOLDOWN = 2'd3
  } slot_state_t;

  localparam int COORD_W_DEFAULT = 6;
  localparam int BLAST_RADIUS    = 1;

  function automatic logic in_blast(input int unsigned px,
                                    input int unsigned py,
                                    input int unsigned bx,
                                    input int unsigned by);
    int unsigned dx;
    int unsigned dy;
    dx = (px > bx) ? (px - bx) : (bx - px);
    dy = (py > by) ? (py - by) : (by - py);
    return (dx <= int'(BLAST_RADIUS)) && (dy <= int'(BLAST_RADIUS));
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One player's bomb slot: IDLE -> ARMED (FUSE_T cycles) -> EXPLODE (1 cycle) -> COOLDOWN (CD_T cycles).
// Bomb is active the cycle after an accepted place; place is ignored outside IDLE or while stunned.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int CNT_W   = 4,
  parameter int FUSE_T  = 12,
  parameter int CD_T    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_place,
  input  logic               i_stunned,
  input  logic [COORD_W-1:0] i_pos_x,
  input  logic [COORD_W-1:0] i_pos_y,
  output logic               o_active,
  output logic               o_explode,
  output logic [COORD_W-1:0] o_bomb_x,
  output logic [COORD_W-1:0] o_bomb_y
);

  slot_state_t        r_state;
  slot_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_latch;
  logic [COORD_W-1:0] r_bomb_x;
  logic [COORD_W-1:0] r_bomb_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bomb_x <= '0;
      r_bomb_y <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_bomb_x <= i_pos_x;
        r_bomb_y <= i_pos_y;
      end
    end
  end

  // The same counter times the fuse and then the cooldown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_place && !i_stunned) begin
          w_state_nxt = ARMED;
          w_cnt_nxt   = CNT_W'(FUSE_T - 1);
          w_latch     = 1'b1;
        end
      end
      ARMED: begin
        if (r_cnt == '0) w_state_nxt = EXPLODE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      EXPLODE: begin
        w_state_nxt = COOLDOWN;
        w_cnt_nxt   = CNT_W'(CD_T - 1);
      end
      COOLDOWN: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    o_active  = (r_state == ARMED);
    o_explode = (r_state == EXPLODE);
    o_bomb_x  = r_bomb_x;
    o_bomb_y  = r_bomb_y;
  end

endmodule

// File: rtl/bomb_stun_controller.sv
// Two bomb slots plus per-player stun timers; a hit in the explode cycle stuns from the next cycle.
// Stun reloads to the full duration on any hit; simultaneous hits on one player count once.
module bomb_stun_controller
  import bomb_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int FUSE_SEC      = 3,
  parameter int STUN_SEC      = 5,
  parameter int COOLDOWN_SEC  = 1,
  parameter int COORD_W       = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               red_place,
  input  logic               blue_place,
  input  logic [COORD_W-1:0] red_pos_x,
  input  logic [COORD_W-1:0] red_pos_y,
  input  logic [COORD_W-1:0] blue_pos_x,
  input  logic [COORD_W-1:0] blue_pos_y,
  output logic               red_bomb_active,
  output logic [COORD_W-1:0] red_bomb_x,
  output logic [COORD_W-1:0] red_bomb_y,
  output logic               blue_bomb_active,
  output logic [COORD_W-1:0] blue_bomb_x,
  output logic [COORD_W-1:0] blue_bomb_y,
  output logic               red_explode,
  output logic               blue_explode,
  output logic               red_stunned,
  output logic               blue_stunned
);

  localparam int FUSE_T  = FUSE_SEC * TICKS_PER_SEC;
  localparam int STUN_T  = STUN_SEC * TICKS_PER_SEC;
  localparam int CD_T    = COOLDOWN_SEC * TICKS_PER_SEC;
  localparam int MAX_FC  = (FUSE_T > CD_T) ? FUSE_T : CD_T;
  localparam int MAX_T   = (MAX_FC > STUN_T) ? MAX_FC : STUN_T;
  localparam int CNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  // Index 0 is red, index 1 is blue.
  logic [1:0]       r_stunned;
  logic [CNT_W-1:0] r_stun_cnt [2];
  logic [1:0]       w_hit;

  bomb_slot #(
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W),
    .FUSE_T  (FUSE_T),
    .CD_T    (CD_T)
  ) u_red_slot (
    .clk       (clk),
    .reset     (reset),
    .i_place   (red_place),
    .i_stunned (r_stunned[0]),
    .i_pos_x   (red_pos_x),
    .i_pos_y   (red_pos_y),
    .o_active  (red_bomb_active),
    .o_explode (red_explode),
    .o_bomb_x  (red_bomb_x),
    .o_bomb_y  (red_bomb_y)
  );

  bomb_slot #(
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W),
    .FUSE_T  (FUSE_T),
    .CD_T    (CD_T)
  ) u_blue_slot (
    .clk       (clk),
    .reset     (reset),
    .i_place   (blue_place),
    .i_stunned (r_stunned[1]),
    .i_pos_x   (blue_pos_x),
    .i_pos_y   (blue_pos_y),
    .o_active  (blue_bomb_active),
    .o_explode (blue_explode),
    .o_bomb_x  (blue_bomb_x),
    .o_bomb_y  (blue_bomb_y)
  );

  always_comb begin
    w_hit[0] = (red_explode  && in_blast(32'(red_pos_x),  32'(red_pos_y),  32'(red_bomb_x),  32'(red_bomb_y)))
            || (blue_explode && in_blast(32'(red_pos_x),  32'(red_pos_y),  32'(blue_bomb_x), 32'(blue_bomb_y)));
    w_hit[1] = (red_explode  && in_blast(32'(blue_pos_x), 32'(blue_pos_y), 32'(red_bomb_x),  32'(red_bomb_y)))
            || (blue_explode && in_blast(32'(blue_pos_x), 32'(blue_pos_y), 32'(blue_bomb_x), 32'(blue_bomb_y)));
  end

  // A hit always wins over expiry, so a hit on the last stun cycle keeps stunned high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stunned <= '0;
      for (int i = 0; i < 2; i++) r_stun_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_hit[i]) begin
          r_stunned[i]  <= 1'b1;
          r_stun_cnt[i] <= CNT_W'(STUN_T - 1);
        end else if (r_stunned[i]) begin
          if (r_stun_cnt[i] == '0) r_stunned[i]  <= 1'b0;
          else                     r_stun_cnt[i] <= r_stun_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    red_stunned  = r_stunned[0];
    blue_stunned = r_stunned[1];
  end

endmodule

// File: tb/tb_bomb_stun_controller.sv
// Directed bench for bomb_stun_controller with TICKS_PER_SEC=4 (fuse 12, stun 20, cooldown 4 cycles).
module tb_bomb_stun_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       red_place, blue_place;
  logic [5:0] red_pos_x, red_pos_y, blue_pos_x, blue_pos_y;
  logic       red_bomb_active, blue_bomb_active;
  logic [5:0] red_bomb_x, red_bomb_y, blue_bomb_x, blue_bomb_y;
  logic       red_explode, blue_explode, red_stunned, blue_stunned;

  int n_assert = 0;
  int n_fail   = 0;
  logic [5:0] seen;

  always #5 clk = ~clk;

  bomb_stun_controller #(.TICKS_PER_SEC(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .red_place        (red_place),
    .blue_place       (blue_place),
    .red_pos_x        (red_pos_x),
    .red_pos_y        (red_pos_y),
    .blue_pos_x       (blue_pos_x),
    .blue_pos_y       (blue_pos_y),
    .red_bomb_active  (red_bomb_active),
    .red_bomb_x       (red_bomb_x),
    .red_bomb_y       (red_bomb_y),
    .blue_bomb_active (blue_bomb_active),
    .blue_bomb_x      (blue_bomb_x),
    .blue_bomb_y      (blue_bomb_y),
    .red_explode      (red_explode),
    .blue_explode     (blue_explode),
    .red_stunned      (red_stunned),
    .blue_stunned     (blue_stunned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({red_bomb_active, red_bomb_x, red_bomb_y, blue_bomb_active, blue_bomb_x,
                  blue_bomb_y, red_explode, blue_explode, red_stunned, blue_stunned}), 0);
  endtask

  task automatic set_pos(input int rx, input int ry, input int bx, input int by);
    red_pos_x  = 6'(rx);
    red_pos_y  = 6'(ry);
    blue_pos_x = 6'(bx);
    blue_pos_y = 6'(by);
  endtask

  task automatic do_reset();
    red_place  = 1'b0;
    blue_place = 1'b0;
    reset      = 1'b1;
    steps(2);
    reset      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, assertions %0d failures %0d", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    set_pos(0, 0, 0, 0);
    do_reset();
    chk_all_zero("reset_state");

    // 1: plain fuse/explode/cooldown, nobody in the blast
    set_pos(10, 10, 30, 30);
    red_place = 1'b1; step(); red_place = 1'b0;
    chk("s1_active_rise", 32'(red_bomb_active), 1);
    chk("s1_bomb_xy", 32'({red_bomb_x, red_bomb_y}), 32'({6'd10, 6'd10}));
    set_pos(20, 20, 30, 30);
    for (int i = 2; i <= 12; i++) begin
      step();
      chk("s1_armed", 32'({red_bomb_active, red_explode}), 32'b10);
    end
    step();
    chk("s1_explode", 32'({red_bomb_active, red_explode}), 32'b01);
    step();
    chk("s1_no_stun", 32'({red_stunned, blue_stunned, red_explode}), 0);
    steps(3);
    red_place = 1'b1; step(); red_place = 1'b0;
    chk("s1_replace_in_cooldown", 32'(red_bomb_active), 0);
    red_place = 1'b1; step(); red_place = 1'b0;
    chk("s1_replace_accepted", 32'(red_bomb_active), 1);
    chk("s1_blue_idle", 32'(blue_bomb_active), 0);

    // 2: blue walks into red's blast; red stays on its own bomb
    do_reset();
    set_pos(10, 10, 30, 30);
    red_place = 1'b1; step(); red_place = 1'b0;
    set_pos(10, 10, 11, 9);
    steps(11);
    step();
    chk("s2_explode", 32'({red_explode, red_stunned, blue_stunned}), 32'b100);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("s2_stunned", 32'({red_stunned, blue_stunned}), 32'b11);
    end
    step();
    chk("s2_stun_clear", 32'({red_stunned, blue_stunned}), 0);

    // 3: grid edges, no wrap from x=0 to x=63; corner (63,63) reaches (62,62)
    do_reset();
    set_pos(0, 5, 63, 63);
    red_place = 1'b1; blue_place = 1'b1; step(); red_place = 1'b0; blue_place = 1'b0;
    chk("s3_red_xy", 32'({red_bomb_x, red_bomb_y}), 32'({6'd0, 6'd5}));
    chk("s3_blue_xy", 32'({blue_bomb_x, blue_bomb_y}), 32'({6'd63, 6'd63}));
    set_pos(62, 62, 63, 5);
    steps(11);
    step();
    chk("s3_explode_both", 32'({red_explode, blue_explode}), 32'b11);
    step();
    chk("s3_edge_stun", 32'({red_stunned, blue_stunned}), 32'b10);

    // 4: blue inside both blasts in the same cycle -> single 20-cycle stun
    do_reset();
    set_pos(10, 10, 11, 11);
    red_place = 1'b1; blue_place = 1'b1; step(); red_place = 1'b0; blue_place = 1'b0;
    set_pos(40, 40, 11, 11);
    steps(11);
    step();
    chk("s4_explode_both", 32'({red_explode, blue_explode}), 32'b11);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("s4_stunned", 32'({red_stunned, blue_stunned}), 32'b01);
    end
    step();
    chk("s4_stun_clear", 32'(blue_stunned), 0);

    // 5: re-hit 15 cycles into a stun, while blue requests placement every cycle
    do_reset();
    set_pos(40, 40, 11, 11);
    blue_place = 1'b1; step(); blue_place = 1'b0;        // cycle 1
    steps(12);                                            // cycle 13
    chk("s5_blue_explode", 32'(blue_explode), 1);
    step();                                               // cycle 14
    chk("s5_blue_stun_start", 32'(blue_stunned), 1);
    step();                                               // cycle 15
    set_pos(12, 12, 11, 11);
    red_place = 1'b1; step(); red_place = 1'b0;           // cycle 16
    set_pos(40, 40, 11, 11);
    chk("s5_red_xy", 32'({red_bomb_active, red_bomb_x, red_bomb_y}), 32'({1'b1, 6'd12, 6'd12}));
    blue_place = 1'b1;
    for (int cyc = 17; cyc <= 48; cyc++) begin
      step();
      if (cyc == 28) chk("s5_red_explode", 32'(red_explode), 1);
      chk("s5_stunned_no_place", 32'({blue_stunned, blue_bomb_active, red_stunned}), 32'b100);
    end
    step();                                               // cycle 49
    chk("s5_stun_clear_cycle", 32'({blue_stunned, blue_bomb_active}), 0);
    step();                                               // cycle 50
    blue_place = 1'b0;
    chk("s5_place_after_clear", 32'(blue_bomb_active), 1);

    // 6: reset mid-fuse (red) and mid-stun (blue)
    do_reset();
    set_pos(20, 20, 50, 50);
    blue_place = 1'b1; step(); blue_place = 1'b0;        // cycle 1
    steps(13);                                            // cycle 14
    chk("s6_blue_stunned", 32'(blue_stunned), 1);
    red_place = 1'b1; step(); red_place = 1'b0;           // cycle 15
    chk("s6_red_armed", 32'(red_bomb_active), 1);
    steps(5);                                             // cycle 20
    reset = 1'b1;
    step();
    chk_all_zero("s6_reset_abort");
    step();
    reset = 1'b0;
    chk_all_zero("s6_reset_hold");
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | {red_explode, blue_explode, red_stunned, blue_stunned,
                     red_bomb_active, blue_bomb_active};
    end
    chk("s6_no_late_event", 32'(seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
